// File: rtl/intr_ctrl.sv
// Priority interrupt controller: APB-style register file of per-source priorities plus a
// two-state arbiter that latches one winner and holds it until the servicer acknowledges it.
module intr_ctrl #(
    parameter int  NUM_INTR = 16,
    localparam int IW       = $clog2(NUM_INTR)
) (
    input  logic                pclk_i,
    input  logic                prst_i,
    input  logic [7:0]          paddr_i,
    input  logic [7:0]          pwdata_i,
    output logic [7:0]          prdata_o,
    input  logic                pwrite_i,
    input  logic                penable_i,
    output logic                pready_o,
    output logic                perror_o,
    input  logic [NUM_INTR-1:0] intr_active_i,
    input  logic                intr_serviced_i,
    output logic [IW-1:0]       intr_to_service_o,
    output logic                intr_valid_o
);

    localparam logic [0:0] ST_IDLE         = 1'b0;
    localparam logic [0:0] ST_WAIT_SERVICE = 1'b1;

    logic [3:0]    prio [NUM_INTR];
    logic          addr_ok;
    logic [IW-1:0] reg_idx;
    logic [0:0]    state;
    logic          win_found;
    logic [3:0]    win_prio;
    logic [IW-1:0] win_idx;

    assign addr_ok  = (int'(paddr_i) < NUM_INTR);
    assign reg_idx  = paddr_i[IW-1:0];
    assign pready_o = penable_i;
    assign perror_o = penable_i && !addr_ok;
    assign prdata_o = (penable_i && !pwrite_i && addr_ok) ? {4'b0000, prio[reg_idx]} : 8'h00;

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            for (int i = 0; i < NUM_INTR; i++) begin
                prio[i] <= 4'h0;
            end
        end else if (penable_i && pwrite_i && addr_ok) begin
            prio[reg_idx] <= pwdata_i[3:0];
        end
    end

    // Scanning from the top index down with >= lets the lowest index win a priority tie.
    always_comb begin
        win_found = 1'b0;
        win_prio  = 4'h0;
        win_idx   = '0;
        for (int i = NUM_INTR - 1; i >= 0; i--) begin
            if (intr_active_i[i] && (!win_found || prio[i] >= win_prio)) begin
                win_found = 1'b1;
                win_prio  = prio[i];
                win_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state             <= ST_IDLE;
            intr_to_service_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state             <= ST_WAIT_SERVICE;
                        intr_to_service_o <= win_idx;
                    end
                end
                ST_WAIT_SERVICE: begin
                    if (intr_serviced_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign intr_valid_o = (state == ST_WAIT_SERVICE);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a vector table for register access and basic arbitration,
// then hand-written sequences for full grant orders, pending-grant stability and async reset.
module tb_intr_ctrl;

    logic        pclk_i = 1'b0;
    logic        prst_i;
    logic [7:0]  paddr_i;
    logic [7:0]  pwdata_i;
    logic [7:0]  prdata_o;
    logic        pwrite_i;
    logic        penable_i;
    logic        pready_o;
    logic        perror_o;
    logic [15:0] intr_active_i;
    logic        intr_serviced_i;
    logic [3:0]  intr_to_service_o;
    logic        intr_valid_o;

    int n_vec = 0;
    int n_err = 0;

    intr_ctrl #(.NUM_INTR(16)) dut (
        .pclk_i            (pclk_i),
        .prst_i            (prst_i),
        .paddr_i           (paddr_i),
        .pwdata_i          (pwdata_i),
        .prdata_o          (prdata_o),
        .pwrite_i          (pwrite_i),
        .penable_i         (penable_i),
        .pready_o          (pready_o),
        .perror_o          (perror_o),
        .intr_active_i     (intr_active_i),
        .intr_serviced_i   (intr_serviced_i),
        .intr_to_service_o (intr_to_service_o),
        .intr_valid_o      (intr_valid_o)
    );

    always #5 pclk_i = ~pclk_i;

    typedef struct {
        logic        en;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] act;
        logic        svc;
        logic [7:0]  exp_rd;
        logic        exp_err;
        logic        exp_vld;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic idle_bus();
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        paddr_i   = 8'h00;
        pwdata_i  = 8'h00;
    endtask

    task automatic write_prio(input logic [7:0] a, input logic [7:0] d);
        penable_i = 1'b1;
        pwrite_i  = 1'b1;
        paddr_i   = a;
        pwdata_i  = d;
        step();
        idle_bus();
    endtask

    task automatic do_reset();
        prst_i = 1'b0;
        #3;
        prst_i = 1'b1;
        #1;
    endtask

    task automatic wait_grant(input string nm, input logic [3:0] exp_idx);
        int k;
        k = 0;
        while (!intr_valid_o && k < 4) begin
            step();
            k++;
        end
        chk({nm, " valid"}, 32'(intr_valid_o), 32'd1);
        chk({nm, " index"}, 32'(intr_to_service_o), 32'(exp_idx));
    endtask

    task automatic service_and_drop(input string nm, input logic [3:0] idx);
        intr_active_i[idx] = 1'b0;
        intr_serviced_i    = 1'b1;
        step();
        intr_serviced_i    = 1'b0;
        chk({nm, " gap after service"}, 32'(intr_valid_o), 32'd0);
    endtask

    logic [3:0] order_a5 [8];

    initial begin
        idle_bus();
        intr_active_i   = 16'h0000;
        intr_serviced_i = 1'b0;
        prst_i          = 1'b0;
        #2;
        chk("reset valid", 32'(intr_valid_o), 32'd0);
        chk("reset index", 32'(intr_to_service_o), 32'd0);
        chk("reset prdata", 32'(prdata_o), 32'd0);
        chk("reset pready", 32'(pready_o), 32'd0);
        chk("reset perror", 32'(perror_o), 32'd0);
        @(negedge pclk_i);
        prst_i = 1'b1;
        step();

        //            en    wr    addr   wdata  act       svc   rd     err   vld   idx
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 8'h03, 8'hF9, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 8'h03, 8'h00, 16'h0000, 1'b0, 8'h09, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'h20, 8'h0F, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'h20, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0030, 1'b0, 8'h00, 1'b0, 1'b1, 4'd4};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0030, 1'b0, 8'h00, 1'b0, 1'b1, 4'd4};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0020, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0020, 1'b0, 8'h00, 1'b0, 1'b1, 4'd5};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[13] = '{1'b1, 1'b1, 8'h05, 8'h07, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[14] = '{1'b1, 1'b1, 8'h03, 8'h01, 16'h0028, 1'b0, 8'h00, 1'b0, 1'b1, 4'd3};
        tbl[15] = '{1'b1, 1'b0, 8'h03, 8'h00, 16'h0028, 1'b0, 8'h01, 1'b0, 1'b1, 4'd3};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0028, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0028, 1'b0, 8'h00, 1'b0, 1'b1, 4'd5};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0};

        for (int i = 0; i < 19; i++) begin
            penable_i       = tbl[i].en;
            pwrite_i        = tbl[i].wr;
            paddr_i         = tbl[i].addr;
            pwdata_i        = tbl[i].wdata;
            intr_active_i   = tbl[i].act;
            intr_serviced_i = tbl[i].svc;
            #1;
            chk($sformatf("vec%0d prdata", i), 32'(prdata_o), 32'(tbl[i].exp_rd));
            chk($sformatf("vec%0d perror", i), 32'(perror_o), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d pready", i), 32'(pready_o), 32'(tbl[i].en));
            step();
            chk($sformatf("vec%0d valid", i), 32'(intr_valid_o), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld)
                chk($sformatf("vec%0d index", i), 32'(intr_to_service_o), 32'(tbl[i].exp_idx));
        end
        idle_bus();
        intr_active_i   = 16'h0000;
        intr_serviced_i = 1'b0;

        // Ascending priorities: all sources active, grants come out highest index first.
        do_reset();
        for (int i = 0; i < 16; i++) write_prio(8'(i), 8'(i));
        intr_active_i = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            wait_grant($sformatf("asc grant%0d", k), 4'(15 - k));
            service_and_drop($sformatf("asc grant%0d", k), 4'(15 - k));
        end
        step();
        chk("asc drained valid", 32'(intr_valid_o), 32'd0);

        // Descending priorities on a sparse request mask.
        do_reset();
        for (int i = 0; i < 16; i++) write_prio(8'(i), 8'(15 - i));
        order_a5 = '{4'd0, 4'd2, 4'd5, 4'd7, 4'd8, 4'd10, 4'd13, 4'd15};
        intr_active_i = 16'hA5A5;
        for (int k = 0; k < 8; k++) begin
            wait_grant($sformatf("a5a5 grant%0d", k), order_a5[k]);
            service_and_drop($sformatf("a5a5 grant%0d", k), order_a5[k]);
        end
        step();
        chk("a5a5 drained valid", 32'(intr_valid_o), 32'd0);

        // A higher-priority request and a priority rewrite during a pending grant are ignored.
        do_reset();
        write_prio(8'd6, 8'd2);
        write_prio(8'd9, 8'd10);
        intr_active_i = 16'h0040;
        step();
        chk("pend first valid", 32'(intr_valid_o), 32'd1);
        chk("pend first index", 32'(intr_to_service_o), 32'd6);
        intr_active_i = 16'h0240;
        write_prio(8'd6, 8'd15);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("pend hold%0d valid", k), 32'(intr_valid_o), 32'd1);
            chk($sformatf("pend hold%0d index", k), 32'(intr_to_service_o), 32'd6);
        end
        service_and_drop("pend", 4'd6);
        step();
        chk("pend next valid", 32'(intr_valid_o), 32'd1);
        chk("pend next index", 32'(intr_to_service_o), 32'd9);

        // Reset mid-service drops the grant without a clock edge, then lowest index wins.
        write_prio(8'd12, 8'd9);
        intr_active_i = 16'h1008;
        #2;
        prst_i = 1'b0;
        #1;
        chk("async rst valid", 32'(intr_valid_o), 32'd0);
        chk("async rst index", 32'(intr_to_service_o), 32'd0);
        @(negedge pclk_i);
        prst_i = 1'b1;
        penable_i = 1'b1;
        paddr_i   = 8'd12;
        #1;
        chk("post rst prio12", 32'(prdata_o), 32'd0);
        idle_bus();
        step();
        chk("post rst valid", 32'(intr_valid_o), 32'd1);
        chk("post rst index", 32'(intr_to_service_o), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
